// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: FSM state codes, frame
// opcodes, frame kinds and the helper that assembles an 11-bit MOSI frame.
package spi_pkg;

  // Controller states (plain constants so older tools can share the encoding)
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSel     = 3'd1;
  localparam logic [2:0] StShift   = 3'd2;
  localparam logic [2:0] StTurn    = 3'd3;
  localparam logic [2:0] StCapture = 3'd4;
  localparam logic [2:0] StGap     = 3'd5;

  // 3-bit frame opcodes sent ahead of the 8-bit payload
  localparam logic [2:0] OpWrAddr = 3'b000;
  localparam logic [2:0] OpWrData = 3'b001;
  localparam logic [2:0] OpRdAddr = 3'b110;
  localparam logic [2:0] OpRdData = 3'b111;

  localparam int unsigned FrameBits   = 11;
  localparam int unsigned CaptureBits = 8;

  typedef enum logic [1:0] {
    FrWrAddr,
    FrWrData,
    FrRdAddr,
    FrRdData
  } frame_e;

  // Opcode followed by payload; RD_DATA carries eight dummy zeros.
  function automatic logic [10:0] frame_word(frame_e kind, logic [7:0] addr, logic [7:0] wdata);
    logic [10:0] word;
    word = '0;
    unique case (kind)
      FrWrAddr: word = {OpWrAddr, addr};
      FrWrData: word = {OpWrData, wdata};
      FrRdAddr: word = {OpRdAddr, addr};
      FrRdData: word = {OpRdData, 8'h00};
      default:  word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bundle of the SPI master controller.
interface spi_master_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       done;
  logic [7:0] rd_data;

  // Host that issues requests
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, done, rd_data
  );

  // Controller that serves requests
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, done, rd_data
  );
endinterface

// File: rtl/spi_master_shift.sv
// 11-bit MOSI load/shift register with its bit counter. A load takes priority
// over a shift; o_cnt reports how many bits have been shifted out since load.
module spi_master_shift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [10:0] i_frame,
  input  logic        i_shift,
  output logic        o_msb,
  output logic [3:0]  o_cnt
);

  logic [10:0] r_sreg;
  logic [3:0]  r_cnt;

  // Load a fresh frame or move the next bit into the MSB position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_frame;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[9:0], 1'b0};
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  assign o_msb = r_sreg[10];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns single host read/write requests into two-frame
// SPI transactions (address frame, then data frame) towards a RAM slave.
// Optional feature: define SPI_MASTER_ADDR_CACHE_EN to skip an address frame
// when the address matches the last one sent for the same direction.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.slave  bus,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  logic [2:0]  r_state, w_state_d;
  frame_e      r_frame, w_frame_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [7:0]  r_wdata;
  logic [7:0]  r_cap, w_cap_d;
  logic [7:0]  r_rd_data;
  logic        r_done, r_ss_n, r_mosi, r_ready;

  logic        w_accept, w_load, w_shift, w_last, w_capture_end;
  logic        w_wr_hit, w_rd_hit;
  logic [7:0]  w_wdata_sel;
  logic [10:0] w_frame_word;
  logic        w_msb;
  logic [3:0]  w_bit_cnt;

  assign w_accept    = (r_state == StIdle) && r_ready && bus.req_valid;
  assign w_last      = (r_frame == FrWrData) || (r_frame == FrRdData);
  // On acceptance the request inputs feed the first frame directly.
  assign w_wdata_sel = w_accept ? bus.req_wdata : r_wdata;
  assign w_frame_word = frame_word(w_frame_d, bus.req_addr, w_wdata_sel);

`ifdef SPI_MASTER_ADDR_CACHE_EN
  logic [7:0] r_wr_cache_addr, r_rd_cache_addr;
  logic       r_wr_cache_vld, r_rd_cache_vld;

  assign w_wr_hit = r_wr_cache_vld && (r_wr_cache_addr == bus.req_addr);
  assign w_rd_hit = r_rd_cache_vld && (r_rd_cache_addr == bus.req_addr);

  // Remember the last address sent per direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cache_addr <= '0;
      r_wr_cache_vld  <= 1'b0;
      r_rd_cache_addr <= '0;
      r_rd_cache_vld  <= 1'b0;
    end else if (w_accept) begin
      if (bus.req_write) begin
        r_wr_cache_addr <= bus.req_addr;
        r_wr_cache_vld  <= 1'b1;
      end else begin
        r_rd_cache_addr <= bus.req_addr;
        r_rd_cache_vld  <= 1'b1;
      end
    end
  end
`else
  assign w_wr_hit = 1'b0;
  assign w_rd_hit = 1'b0;
`endif

  spi_master_shift u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_frame (w_frame_word),
    .i_shift (w_shift),
    .o_msb   (w_msb),
    .o_cnt   (w_bit_cnt)
  );

  // Next-state, frame sequencing and MISO capture
  always_comb begin
    w_state_d     = r_state;
    w_frame_d     = r_frame;
    w_cnt_d       = r_cnt;
    w_cap_d       = r_cap;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_capture_end = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StSel;
          w_load    = 1'b1;
          if (bus.req_write) w_frame_d = w_wr_hit ? FrWrData : FrWrAddr;
          else               w_frame_d = w_rd_hit ? FrRdData : FrRdAddr;
        end
      end
      StSel: begin
        w_state_d = StShift;
        w_shift   = 1'b1;
      end
      StShift: begin
        if (w_bit_cnt == 4'(FrameBits)) begin
          w_cnt_d   = '0;
          w_state_d = (r_frame == FrRdData) ? StTurn : StGap;
        end else begin
          w_shift = 1'b1;
        end
      end
      StTurn: begin
        if (r_cnt == 4'(TURN_CYCLES - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StCapture;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StCapture: begin
        w_cap_d = {r_cap[6:0], MISO};
        if (r_cnt == 4'(CaptureBits - 1)) begin
          w_capture_end = 1'b1;
          w_cnt_d       = '0;
          w_state_d     = StGap;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StGap: begin
        if (r_cnt == 4'(GAP_CYCLES - 1)) begin
          w_cnt_d = '0;
          if (w_last) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StSel;
            w_load    = 1'b1;
            w_frame_d = (r_frame == FrWrAddr) ? FrWrData : FrRdData;
          end
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_frame <= FrWrAddr;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_d;
      r_frame <= w_frame_d;
      r_cnt   <= w_cnt_d;
      r_cap   <= w_cap_d;
      if (w_accept) r_wdata <= bus.req_wdata;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ss_n  <= !((w_state_d == StSel) || (w_state_d == StShift) ||
                   (w_state_d == StTurn) || (w_state_d == StCapture));
      r_mosi  <= w_shift & w_msb;
      r_ready <= (w_state_d == StIdle);
      r_done  <= (w_state_d == StGap) && (r_state != StGap) && w_last;
      // rd_data only changes once all eight bits are in
      if (w_capture_end) r_rd_data <= w_cap_d;
    end
  end

  assign SS_n          = r_ss_n;
  assign MOSI          = r_mosi;
  assign bus.req_ready = r_ready;
  assign bus.done      = r_done;
  assign bus.rd_data   = r_rd_data;

endmodule
